// File: rtl/fft32_bin_serializer_if.sv
// Handshake bundle for the FFT bin serializer: parallel frame in, one complex bin per beat out.
interface fft32_bin_serializer_if #(
  parameter int N = 32,
  parameter int W = 11
);
  logic                in_valid;
  logic [N*W-1:0]      in_real;
  logic [N*W-1:0]      in_imag;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_imag;
  logic [4:0]          out_index;
  logic                out_last;
  logic                overflow;
  logic [7:0]          drop_count;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last,
           overflow, drop_count
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last,
           overflow, drop_count
  );
endinterface

// File: rtl/fft32_bin_serializer.sv
// Ping-pong buffered serializer: captures a 32-bin complex frame in one cycle and
// streams it out one bin per accepted beat; frames arriving with both buffers full are dropped.
module fft32_bin_serializer #(
  parameter int N = 32,
  parameter int W = 11
) (
  input logic                  clk,
  input logic                  rst,
  fft32_bin_serializer_if.slave bus
);

  logic signed [W-1:0] buf_re [2][N];
  logic signed [W-1:0] buf_im [2][N];

  logic       wr_buf;
  logic       rd_buf;
  logic [1:0] count;
  logic [4:0] idx;
  logic       overflow_q;
  logic [7:0] drop_q;

  logic accept;
  logic xfer;
  logic fin;
  logic drop;

  // Handshake flags come only from registered occupancy, never from the inputs.
  assign bus.in_ready   = (count < 2'd2);
  assign bus.out_valid  = (count != 2'd0);
  assign bus.out_real   = buf_re[rd_buf][idx];
  assign bus.out_imag   = buf_im[rd_buf][idx];
  assign bus.out_index  = idx;
  assign bus.out_last   = (idx == 5'd31);
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign drop   = bus.in_valid && !bus.in_ready;
  assign xfer   = bus.out_valid && bus.out_ready;
  assign fin    = xfer && (idx == 5'd31);

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      idx        <= 5'd0;
      wr_buf     <= 1'b0;
      rd_buf     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      if (accept) wr_buf <= ~wr_buf;
      if (xfer) begin
        idx <= idx + 5'd1;
        if (fin) rd_buf <= ~rd_buf;
      end
      // Capture and final-bin release on the same edge cancel out.
      case ({accept, fin})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      overflow_q <= drop;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Frame storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int k = 0; k < N; k++) begin
        buf_re[wr_buf][k] <= bus.in_real[W*k +: W];
        buf_im[wr_buf][k] <= bus.in_imag[W*k +: W];
      end
    end
  end

endmodule

// File: tb/tb_fft32_bin_serializer.sv
// Scoreboard bench for fft32_bin_serializer: stimulus pushes expected beats, a negedge
// monitor pops and compares every transferred bin and checks stall stability.
module tb_fft32_bin_serializer;
  localparam int N = 32;
  localparam int W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft32_bin_serializer_if #(.N(N), .W(W)) bus ();
  fft32_bin_serializer #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [4:0]   idx;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Frame 0 is the ramp k / -k; other frames use distinct signed ramps.
  function automatic logic [W-1:0] gen_re(input int f, input int k);
    if (f == 0) return W'(k);
    return W'(f*200 - 1000 + k*7);
  endfunction

  function automatic logic [W-1:0] gen_im(input int f, input int k);
    if (f == 0) return W'(-k);
    return W'(900 - f*150 - k*5);
  endfunction

  task automatic load_frame(input int f);
    for (int k = 0; k < N; k++) begin
      bus.in_real[W*k +: W] = gen_re(f, k);
      bus.in_imag[W*k +: W] = gen_im(f, k);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the offering edge.
  task automatic send_frame(input int f, input bit expect_ok);
    load_frame(f);
    check($sformatf("in_ready_f%0d", f), 32'(bus.in_ready), 32'(expect_ok));
    bus.in_valid = 1'b1;
    if (expect_ok)
      for (int k = 0; k < N; k++)
        exp_q.push_back('{gen_re(f, k), gen_im(f, k), 5'(k), (k == N-1)});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic wait_index(input logic [4:0] target, input int budget);
    int n = 0;
    while (!(bus.out_valid && bus.out_index == target) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_index", 32'(bus.out_index), 32'(target));
  endtask

  // Monitor: pop on each transfer, and require held outputs across stalls.
  initial begin
    bit    stall;
    beat_t held;
    beat_t b;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        total++;
        if (!bus.out_valid ||
            {bus.out_real, bus.out_imag, bus.out_index, bus.out_last} !==
            {held.re, held.im, held.idx, held.last}) begin
          bad++;
          $display("FAIL stall_hold actual v=%0b idx=%0d re=%0h im=%0h required v=1 idx=%0d re=%0h im=%0h",
                   bus.out_valid, bus.out_index, bus.out_real, bus.out_imag, held.idx, held.re, held.im);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat actual idx=%0d required none", bus.out_index);
        end else begin
          b = exp_q.pop_front();
          if ({bus.out_real, bus.out_imag, bus.out_index, bus.out_last} !==
              {b.re, b.im, b.idx, b.last}) begin
            bad++;
            $display("FAIL beat actual idx=%0d re=%0h im=%0h last=%0b required idx=%0d re=%0h im=%0h last=%0b",
                     bus.out_index, bus.out_real, bus.out_imag, bus.out_last, b.idx, b.re, b.im, b.last);
          end
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      held  = '{bus.out_real, bus.out_imag, bus.out_index, bus.out_last};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_index", 32'(bus.out_index), 32'd0);
    check("rst_drop_count", 32'(bus.drop_count), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);

    // Single ramp frame, downstream always ready.
    bus.out_ready = 1'b1;
    send_frame(0, 1'b1);
    check("latency_out_valid", 32'(bus.out_valid), 32'd1);
    check("latency_out_index", 32'(bus.out_index), 32'd0);
    drain(1'b0, 60);

    // Random back-pressure.
    send_frame(1, 1'b1);
    drain(1'b1, 400);
    bus.out_ready = 1'b0;

    // Three frames back to back with no drain: third is dropped.
    send_frame(2, 1'b1);
    send_frame(3, 1'b1);
    send_frame(4, 1'b0);
    check("ovf_pulse_hi", 32'(bus.overflow), 32'd1);
    check("ovf_drop_count", 32'(bus.drop_count), 32'd1);
    @(posedge clk); #1;
    check("ovf_pulse_lo", 32'(bus.overflow), 32'd0);
    bus.out_ready = 1'b1;
    drain(1'b0, 120);

    // New frame offered on the bin-31 transfer edge with one frame buffered.
    send_frame(5, 1'b1);
    wait_index(5'd31, 60);
    send_frame(6, 1'b1);
    check("seamless_out_valid", 32'(bus.out_valid), 32'd1);
    check("seamless_out_index", 32'(bus.out_index), 32'd0);
    drain(1'b0, 60);

    // Reset mid-stream with a second frame buffered and a frame on the input.
    bus.out_ready = 1'b0;
    send_frame(7, 1'b1);
    send_frame(8, 1'b1);
    bus.out_ready = 1'b1;
    wait_index(5'd10, 60);
    rst = 1'b1;
    load_frame(9);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_drop_count", 32'(bus.drop_count), 32'd0);
    check("midrst_out_index", 32'(bus.out_index), 32'd0);
    send_frame(9, 1'b1);
    check("midrst_restart_index", 32'(bus.out_index), 32'd0);
    drain(1'b0, 60);

    // 300 consecutive drops with both buffers full.
    bus.out_ready = 1'b0;
    send_frame(10, 1'b1);
    send_frame(11, 1'b1);
    load_frame(12);
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      check($sformatf("sat_overflow_%0d", i), 32'(bus.overflow), 32'd1);
      check($sformatf("sat_count_%0d", i), 32'(bus.drop_count), 32'((i > 255) ? 255 : i));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("sat_overflow_end", 32'(bus.overflow), 32'd0);
    check("sat_count_end", 32'(bus.drop_count), 32'd255);
    bus.out_ready = 1'b1;
    drain(1'b0, 120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft32_bin_serializer.md
FFT32_BIN_SERIALIZER -- requirements
Module: fft32_bin_serializer

Interface
REQ-001 Parameter N, default 32, bins per frame; the block SHALL support only N=32.
REQ-002 Parameter W, default 11, bits per real/imag component (signed, matching the FFT output format).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  parallel frame present on in_real/in_imag this cycle.
REQ-006 in_real  input  N*W  bin k real part at bits [W*k+W-1 : W*k], k=0..31 (k=0 is bin 1 of the FFT output).
REQ-007 in_imag  input  N*W  bin k imag part, same packing as in_real.
REQ-008 in_ready  output  1  block can accept a frame this cycle.
REQ-009 out_valid  output  1  out_real/out_imag/out_index/out_last hold a valid bin.
REQ-010 out_ready  input  1  downstream accepts the current bin.
REQ-011 out_real  output  W  real part of the current bin, signed.
REQ-012 out_imag  output  W  imag part of the current bin, signed.
REQ-013 out_index  output  5  bin number 0..31 of the current bin.
REQ-014 out_last  output  1  high with bin 31 of a frame.
REQ-015 overflow  output  1  one-cycle pulse: frame offered while in_ready low, frame dropped.
REQ-016 drop_count  output  8  number of dropped frames, saturating at 255.

Function
REQ-017 Storage SHALL be two frame buffers of N complex W-bit bins (ping-pong), with write pointer wr_buf, read pointer rd_buf, occupancy count 0..2 and read index idx 0..31.
REQ-018 in_ready SHALL equal (count < 2), combinational from registered state only, never from in_valid or out_ready.
REQ-019 Capture: on an edge with in_valid && in_ready, all 64 components SHALL be written into buffer wr_buf, wr_buf toggles, count increments.
REQ-020 out_valid SHALL equal (count > 0); the outputs SHALL present buffer rd_buf, bin idx, and out_index = idx.
REQ-021 Latency: a frame captured into an empty block SHALL present bin 0 with out_valid high in the cycle after the capture edge.
REQ-022 Transfer occurs on an edge with out_valid && out_ready; idx then increments; an edge with out_valid && !out_ready SHALL leave all outputs unchanged.
REQ-023 On transfer with idx=31 (out_last high): idx wraps to 0, rd_buf toggles, count decrements.
REQ-024 Simultaneous capture and final-bin transfer on one edge: count SHALL be unchanged, both pointers toggle, and streaming continues seamlessly with bin 0 of the next frame on the following cycle.
REQ-025 With count=2 and a last-bin transfer on the same edge as in_valid, the frame SHALL be dropped (in_ready was low in that cycle).
REQ-026 Drop: an edge with in_valid && !in_ready SHALL not modify the buffers or pointers, SHALL set overflow high for exactly the following cycle, and SHALL increment drop_count unless it is 255.
REQ-027 Frames SHALL be emitted in capture order, bins 0..31 in order, with no bin repeated or skipped.
REQ-028 Bin values SHALL pass through bit-exact, with no rounding, scaling or sign change.

Reset
REQ-029 On an edge with rst high: count=0, idx=0, wr_buf=0, rd_buf=0, overflow=0, drop_count=0; consequently out_valid=0, in_ready=1 and out_index=0 in the next cycle.
REQ-030 Reset mid-stream SHALL discard both buffered frames; rst has priority over any concurrent in_valid or out_ready.
REQ-031 Buffer contents SHALL NOT require reset; out_real/out_imag are don't-care while out_valid=0.

Verification
REQ-032 Single frame, bin k real=k and imag=-k, out_ready held high -> 32 consecutive beats, first beat in the cycle after capture, out_index 0..31, out_last only on index 31, in_ready=1 afterwards.
REQ-033 out_ready toggled with a pseudo-random pattern -> outputs stable whenever out_valid && !out_ready, and all 32 bins are delivered exactly once and in order.
REQ-034 Three frames offered on consecutive cycles with out_ready=0 -> frames 1 and 2 are accepted, frame 3 is dropped, overflow pulses for one cycle, drop_count=1, and releasing out_ready then yields 64 beats (frame 1, then frame 2).
REQ-035 With count=1, a new frame is offered on the same edge as the bin-31 transfer -> in_ready=1, the frame is accepted with no gap, and the next beat is bin 0 of the new frame.
REQ-036 rst asserted at bin 10 of frame 1 while frame 2 is buffered -> next cycle out_valid=0, in_ready=1, drop_count=0; a fresh frame then starts at bin 0.
REQ-037 Saturation test: 300 drops -> drop_count stays at 255 and overflow still pulses on every drop.
